// File: rtl/truth_table_scanner_pkg.sv
// Shared types for the truth-table scanner: FSM state encoding and scan-mode constants.
// MODE_SOP emits minterms (f=1), MODE_POS emits maxterms (f=0).
package truth_table_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_SOP = 1'b0;
  localparam logic MODE_POS = 1'b1;

  // A table entry is a term when its value differs from the mode bit.
  function automatic logic is_term(input logic f, input logic mode);
    return f != mode;
  endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// Config/stream bundle between the scanner (slave) and its config source + term consumer (master).
// eval_x/eval_s exist only when EVAL_PORT_EN is defined.
interface truth_table_scanner_if #(
  parameter int N_IN = 3
);

  logic                 tt_load;
  logic [2**N_IN-1:0]   tt_data;
  logic                 mode;
  logic                 start;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [N_IN-1:0]      out_index;
  logic                 done;
  logic [N_IN:0]        term_count;
`ifdef EVAL_PORT_EN
  logic [N_IN-1:0]      eval_x;
  logic                 eval_s;

  modport master (
    output tt_load, tt_data, mode, start, out_ready, eval_x,
    input  busy, out_valid, out_index, done, term_count, eval_s
  );

  modport slave (
    input  tt_load, tt_data, mode, start, out_ready, eval_x,
    output busy, out_valid, out_index, done, term_count, eval_s
  );
`else
  modport master (
    output tt_load, tt_data, mode, start, out_ready,
    input  busy, out_valid, out_index, done, term_count
  );

  modport slave (
    input  tt_load, tt_data, mode, start, out_ready,
    output busy, out_valid, out_index, done, term_count
  );
`endif

endinterface

// File: rtl/truth_table_scanner_tt_term_match.sv
// Combinational table lookup at idx_i compared against the mode bit; zero latency, no flow control.
module tt_term_match
  import truth_table_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic [2**N_IN-1:0] tt_i,
  input  logic [N_IN-1:0]    idx_i,
  input  logic               mode_i,
  output logic               match_o
);

  assign match_o = is_term(tt_i[idx_i], mode_i);

endmodule

// File: rtl/truth_table_scanner.sv
// Truth-table term sequencer: one index per cycle, matching terms stall on out_ready without loss.
// Optional direct lookup port (eval_x -> eval_s, 1-cycle latency) under EVAL_PORT_EN.
module truth_table_scanner
  import truth_table_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  truth_table_scanner_if.slave bus
);

  localparam int              DEPTH    = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(DEPTH - 1);

  state_t             state_q;
  logic [DEPTH-1:0]   tt_q;
  logic [N_IN-1:0]    idx_q;
  logic [N_IN-1:0]    idx_d;
  logic               mode_q;
  logic [N_IN:0]      cnt_q;
  logic [N_IN:0]      cnt_d;
  logic               match;
  logic               advance;

  tt_term_match #(.N_IN(N_IN)) u_scan_match (
    .tt_i    (tt_q),
    .idx_i   (idx_q),
    .mode_i  (mode_q),
    .match_o (match)
  );

  // A non-term moves on unconditionally; a term waits for the consumer.
  assign advance = (state_q == SCAN) && (!match || bus.out_ready);
  assign idx_d   = idx_q + 1'b1;
  assign cnt_d   = cnt_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tt_q    <= '0;
      idx_q   <= '0;
      mode_q  <= MODE_SOP;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.tt_load) tt_q <= bus.tt_data;
          if (bus.start) begin
            mode_q  <= bus.mode;
            idx_q   <= '0;
            cnt_q   <= '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (advance) begin
            if (match) cnt_q <= cnt_d;
            if (idx_q == LAST_IDX) state_q <= DONE;
            else                   idx_q   <= idx_d;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy       = (state_q == SCAN);
  assign bus.out_valid  = (state_q == SCAN) && match;
  assign bus.out_index  = idx_q;
  assign bus.done       = (state_q == DONE);
  assign bus.term_count = cnt_q;

`ifdef EVAL_PORT_EN
  logic eval_match;
  logic eval_s_q;

  tt_term_match #(.N_IN(N_IN)) u_eval_match (
    .tt_i    (tt_q),
    .idx_i   (bus.eval_x),
    .mode_i  (MODE_SOP),
    .match_o (eval_match)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) eval_s_q <= 1'b0;
    else       eval_s_q <= eval_match;
  end

  assign bus.eval_s = eval_s_q;
`endif

endmodule
